ps2_receiver: RTL and testbench



---
 rtl/ps2_receiver.sv | 143 ++++++++++++++
 tb/tb_ps2_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the pins, deserializes
// 11-bit frames and strobes out each valid byte; malformed or stalled frames pulse frame_err.
module ps2_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic       keyboard_rdy,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_d, fall;
  logic [FW-1:0] flt_cnt;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [8:0]    shreg, shreg_n;
  logic [9:0]    frame;
  logic [7:0]    kd_n;
  logic          rdy_n, err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt    <= ~filt;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // shreg holds bits 1..9 once the stop edge arrives; the stop bit is taken live.
  assign frame = {dat_s2, shreg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      to_cnt        <= '0;
      shreg         <= '0;
      keyboard_data <= 8'h00;
      keyboard_rdy  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_n;
      to_cnt        <= to_n;
      shreg         <= shreg_n;
      keyboard_data <= kd_n;
      keyboard_rdy  <= rdy_n;
      frame_err     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    to_n    = to_cnt;
    shreg_n = shreg;
    kd_n    = keyboard_data;
    rdy_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        to_n = '0;
        if (fall && !dat_s2) begin
          state_n = RECV;
          bit_n   = 4'd1;
        end
      end
      RECV: begin
        // An edge wins over a coincident timeout.
        if (fall) begin
          to_n = '0;
          if (bit_cnt == 4'd10) begin
            state_n = CHECK;
            bit_n   = '0;
            if ((^frame[8:0]) && frame[9]) begin
              kd_n  = frame[7:0];
              rdy_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            shreg_n = {dat_s2, shreg[8:1]};
            bit_n   = bit_cnt + 4'd1;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          bit_n   = '0;
          to_n    = '0;
          err_n   = 1'b1;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      CHECK: begin
        state_n = IDLE;
        to_n    = '0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with FILTER_LEN=4, TIMEOUT=1000 and a 100-cycle PS/2 bit period.
module tb_ps2_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard_data;
  logic       keyboard_rdy;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_cnt = 0, err_cnt = 0, wide_cnt = 0;
  int last_rdy_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;
  logic prev_rdy = 1'b0, prev_err = 1'b0;

  ps2_receiver #(.FILTER_LEN(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_data(keyboard_data), .keyboard_rdy(keyboard_rdy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (keyboard_rdy) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      if (prev_rdy) wide_cnt++;
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
      if (prev_err) wide_cnt++;
    end
    prev_rdy = keyboard_rdy;
    prev_err = frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bit(input logic b, input logic g);
    ps2_data = b;
    if (g) begin
      wait_cyc(10);
      glitch();
      wait_cyc(13);
    end else begin
      wait_cyc(25);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(50);
    ps2_clk = 1'b1;
    wait_cyc(25);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_b,
                            input logic g);
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(d[i], g);
    send_bit((~^d) ^ pflip, g);
    send_bit(stop_b, g);
    ps2_data = 1'b1;
    wait_cyc(100);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(4);
    vectors++;
    if (keyboard_data !== 8'h00 || keyboard_rdy !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=%h rdy=%b err=%b want 00/0/0",
               keyboard_data, keyboard_rdy, frame_err);
    end
    reset = 1'b0;
    wait_cyc(20);
  endtask

  task automatic test_valid_frame();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rdy_cnt !== r0 + 1) begin
      miscompares++;
      $display("FAIL valid_rdy_count: got %0d want %0d", rdy_cnt - r0, 1);
    end
    vectors++;
    if (keyboard_data !== 8'h1C) begin
      miscompares++;
      $display("FAIL valid_data: got %h want 1c", keyboard_data);
    end
    // pin fall -> 2 sync flops -> 4 filter samples -> edge cycle -> registered strobe
    vectors++;
    if (last_rdy_cyc - last_fall_cyc !== 7) begin
      miscompares++;
      $display("FAIL valid_latency: got %0d want 7", last_rdy_cyc - last_fall_cyc);
    end
    vectors++;
    if (err_cnt !== e0) begin
      miscompares++;
      $display("FAIL valid_no_err: got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rdy_cnt;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rdy_cnt !== r0 + 1 || keyboard_data !== 8'hF0) begin
      miscompares++;
      $display("FAIL b2b_first: rdys=%0d data=%h want 1/f0", rdy_cnt - r0, keyboard_data);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rdy_cnt !== r0 + 2 || keyboard_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL b2b_second: rdys=%0d data=%h want 2/5a", rdy_cnt - r0, keyboard_data);
    end
  endtask

  task automatic test_bad_frames();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (err_cnt !== e0 + 1 || rdy_cnt !== r0 || keyboard_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL parity_err: errs=%0d rdys=%0d data=%h want 1/0/5a",
               err_cnt - e0, rdy_cnt - r0, keyboard_data);
    end
    vectors++;
    if (last_err_cyc - last_fall_cyc !== 7) begin
      miscompares++;
      $display("FAIL parity_err_latency: got %0d want 7", last_err_cyc - last_fall_cyc);
    end
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== e0 + 2 || rdy_cnt !== r0 || keyboard_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL stop_err: errs=%0d rdys=%0d data=%h want 2/0/5a",
               err_cnt - e0, rdy_cnt - r0, keyboard_data);
    end
  endtask

  task automatic test_timeout();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    ps2_data = 1'b1;
    wait_cyc(1500);
    vectors++;
    if (err_cnt !== e0 + 1 || rdy_cnt !== r0) begin
      miscompares++;
      $display("FAIL timeout_err: errs=%0d rdys=%0d want 1/0", err_cnt - e0, rdy_cnt - r0);
    end
    // edge seen 6 cycles after the pin, then 1000 counter cycles, then the registered strobe
    vectors++;
    if (last_err_cyc - last_fall_cyc !== 1007) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d want 1007", last_err_cyc - last_fall_cyc);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rdy_cnt !== r0 + 1 || keyboard_data !== 8'h5A || err_cnt !== e0 + 1) begin
      miscompares++;
      $display("FAIL timeout_recover: rdys=%0d data=%h errs=%0d want 1/5a/1",
               rdy_cnt - r0, keyboard_data, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      glitch();
      wait_cyc(20);
    end
    vectors++;
    if (rdy_cnt !== r0 || err_cnt !== e0 || keyboard_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL glitch_idle: rdys=%0d errs=%0d data=%h want 0/0/5a",
               rdy_cnt - r0, err_cnt - e0, keyboard_data);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (rdy_cnt !== r0 + 1 || err_cnt !== e0 || keyboard_data !== 8'h1C) begin
      miscompares++;
      $display("FAIL glitch_frame: rdys=%0d errs=%0d data=%h want 1/0/1c",
               rdy_cnt - r0, err_cnt - e0, keyboard_data);
    end
  endtask

  task automatic test_reset_midframe();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(1500);
    vectors++;
    if (rdy_cnt !== r0 || err_cnt !== e0 || keyboard_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_abort: rdys=%0d errs=%0d data=%h want 0/0/00",
               rdy_cnt - r0, err_cnt - e0, keyboard_data);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rdy_cnt !== r0 + 1 || err_cnt !== e0 || keyboard_data !== 8'h1C) begin
      miscompares++;
      $display("FAIL reset_recover: rdys=%0d errs=%0d data=%h want 1/0/1c",
               rdy_cnt - r0, err_cnt - e0, keyboard_data);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_back_to_back();
    test_bad_frames();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    vectors++;
    if (wide_cnt !== 0) begin
      miscompares++;
      $display("FAIL strobe_width: %0d multi-cycle strobes, want 0", wide_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
